// File: rtl/div_sqrt_seq_pkg.sv
// Shared types and constants for the DivSqrtRecF64 issue/response sequencer.
package div_sqrt_seq_pkg;

  // Width of a recoded IEEE double (hardfloat recFN format).
  localparam int REC_F64_W = 65;
  localparam int FLAGS_W   = 5;
  localparam int DSQ_TAG_W = 6;

  typedef enum logic {
    DSQ_IDLE = 1'b0,
    DSQ_BUSY = 1'b1
  } dsq_state_e;

  typedef struct packed {
    logic [REC_F64_W-1:0] out;
    logic [FLAGS_W-1:0]   flags;
    logic [DSQ_TAG_W-1:0] tag;
  } resp_entry_t;

endpackage

// File: rtl/div_sqrt_resp_fifo.sv
// Small synchronous response FIFO with occupancy count and a flush input.
// The caller never pushes when full and never pops when empty.
module div_sqrt_resp_fifo
  import div_sqrt_seq_pkg::*;
#(
  parameter type entry_t = resp_entry_t,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/div_sqrt_rec_f64_seq.sv
// Issue/response sequencer around DivSqrtRecF64. Tracks one op in flight and
// captures the unit's non-stallable result into a small response FIFO.
// Control depends only on handshakes and req_sqrt, never on data values.
// Optional flush support: define DIVSQRT_SEQ_KILL_EN to add the kill port.
// Define DIVSQRT_SEQ_ASSERT_EN to flag stray unit out-valid pulses.
module div_sqrt_rec_f64_seq
  import div_sqrt_seq_pkg::*;
#(
  parameter int TAG_W      = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_sqrt,
  input  logic [REC_F64_W-1:0] req_a,
  input  logic [REC_F64_W-1:0] req_b,
  input  logic [2:0]           req_rm,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 du_inValid,
  output logic                 du_sqrtOp,
  output logic [REC_F64_W-1:0] du_a,
  output logic [REC_F64_W-1:0] du_b,
  output logic [2:0]           du_roundingMode,
  input  logic                 du_inReady_div,
  input  logic                 du_inReady_sqrt,
  input  logic                 du_outValid_div,
  input  logic                 du_outValid_sqrt,
  input  logic [REC_F64_W-1:0] du_out,
  input  logic [FLAGS_W-1:0]   du_exceptionFlags,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [REC_F64_W-1:0] resp_out,
  output logic [FLAGS_W-1:0]   resp_flags,
  output logic [TAG_W-1:0]     resp_tag,
`ifdef DIVSQRT_SEQ_KILL_EN
  input  logic                 kill,
`endif
  output logic                 busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [REC_F64_W-1:0] out;
    logic [FLAGS_W-1:0]   flags;
    logic [TAG_W-1:0]     tag;
  } entry_t;

  dsq_state_e       state;
  logic             op_sqrt;
  logic [TAG_W-1:0] op_tag;
  logic [CNT_W-1:0] fifo_count;
  entry_t           push_entry;
  entry_t           head_entry;
  logic             can_issue;
  logic             fire;
  logic             done;
  logic             push;
  logic             pop;
  logic             flush;
  logic             drop;

`ifdef DIVSQRT_SEQ_KILL_EN
  logic killed;
  assign flush = kill;
  assign drop  = killed || kill;
`else
  assign flush = 1'b0;
  assign drop  = 1'b0;
`endif

  // A FIFO slot must be free before issue since the unit's result cannot wait.
  assign can_issue  = (state == DSQ_IDLE) && (fifo_count < DEPTH_CNT) && !flush;
  assign du_inValid = req_valid && can_issue;
  assign req_ready  = can_issue && (req_sqrt ? du_inReady_sqrt : du_inReady_div);
  assign fire       = req_valid && req_ready;

  assign du_sqrtOp       = req_sqrt;
  assign du_a            = req_a;
  assign du_b            = req_b;
  assign du_roundingMode = req_rm;

  // Only the pulse of the op in flight counts as completion.
  assign done = (state == DSQ_BUSY) && (op_sqrt ? du_outValid_sqrt : du_outValid_div);
  assign push = done && !drop;
  assign pop  = resp_valid && resp_ready;

  assign push_entry = '{out: du_out, flags: du_exceptionFlags, tag: op_tag};

  // Single-op tracker: IDLE until a request fires, BUSY until its completion pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= DSQ_IDLE;
      op_sqrt <= 1'b0;
      op_tag  <= '0;
`ifdef DIVSQRT_SEQ_KILL_EN
      killed  <= 1'b0;
`endif
    end else begin
      case (state)
        DSQ_IDLE: begin
          if (fire) begin
            state   <= DSQ_BUSY;
            op_sqrt <= req_sqrt;
            op_tag  <= req_tag;
`ifdef DIVSQRT_SEQ_KILL_EN
            killed  <= 1'b0;
`endif
          end
        end
        DSQ_BUSY: begin
`ifdef DIVSQRT_SEQ_KILL_EN
          if (kill) begin
            killed <= 1'b1;
          end
`endif
          if (done) begin
            state <= DSQ_IDLE;
          end
        end
        default: state <= DSQ_IDLE;
      endcase
    end
  end

  div_sqrt_resp_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (fifo_count)
  );

  assign resp_valid = (fifo_count != '0);
  assign resp_out   = head_entry.out;
  assign resp_flags = head_entry.flags;
  assign resp_tag   = head_entry.tag;
  assign busy       = (state == DSQ_BUSY);

`ifdef DIVSQRT_SEQ_ASSERT_EN
  // Stray out-valid pulses from the unit point to a protocol problem upstream.
  always_ff @(posedge clock) begin
    if (reset) begin
      assert (!((state == DSQ_IDLE) && (du_outValid_div || du_outValid_sqrt)) &&
              !((state == DSQ_BUSY) && (op_sqrt ? du_outValid_div : du_outValid_sqrt)))
        else $error("unexpected unit out-valid pulse");
    end
  end
`endif

endmodule

// File: tb/tb_div_sqrt_rec_f64_seq.sv
// Self-checking bench for div_sqrt_rec_f64_seq with a stub div/sqrt unit
// (out = a ^ b, flags = 5'h01, fixed latency after accept).
module tb_div_sqrt_rec_f64_seq;

  localparam int TAG_W      = 6;
  localparam int FIFO_DEPTH = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_sqrt = 1'b0;
  logic [64:0]      req_a = '0;
  logic [64:0]      req_b = '0;
  logic [2:0]       req_rm = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             du_inValid;
  logic             du_sqrtOp;
  logic [64:0]      du_a;
  logic [64:0]      du_b;
  logic [2:0]       du_roundingMode;
  logic             du_inReady_div;
  logic             du_inReady_sqrt;
  logic             du_outValid_div;
  logic             du_outValid_sqrt;
  logic [64:0]      du_out;
  logic [4:0]       du_exceptionFlags;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [64:0]      resp_out;
  logic [4:0]       resp_flags;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;
  logic             kill = 1'b0;

  always #5 clock = ~clock;

  div_sqrt_rec_f64_seq #(.TAG_W(TAG_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_sqrt          (req_sqrt),
    .req_a             (req_a),
    .req_b             (req_b),
    .req_rm            (req_rm),
    .req_tag           (req_tag),
    .du_inValid        (du_inValid),
    .du_sqrtOp         (du_sqrtOp),
    .du_a              (du_a),
    .du_b              (du_b),
    .du_roundingMode   (du_roundingMode),
    .du_inReady_div    (du_inReady_div),
    .du_inReady_sqrt   (du_inReady_sqrt),
    .du_outValid_div   (du_outValid_div),
    .du_outValid_sqrt  (du_outValid_sqrt),
    .du_out            (du_out),
    .du_exceptionFlags (du_exceptionFlags),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_out          (resp_out),
    .resp_flags        (resp_flags),
    .resp_tag          (resp_tag),
`ifdef DIVSQRT_SEQ_KILL_EN
    .kill              (kill),
`endif
    .busy              (busy)
  );

  // Stub unit: readiness and stray pulses are bench-controlled, results come
  // stub_lat cycles after an accepted request.
  logic        ready_div = 1'b0;
  logic        ready_sqrt = 1'b0;
  logic        spur_div = 1'b0;
  logic        spur_sqrt = 1'b0;
  int          stub_lat = 1;
  int          stub_cnt;
  logic        stub_op;
  logic [64:0] stub_val;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      stub_cnt <= 0;
      stub_op  <= 1'b0;
      stub_val <= '0;
    end else begin
      if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
      if (du_inValid && (du_sqrtOp ? du_inReady_sqrt : du_inReady_div)) begin
        stub_cnt <= stub_lat;
        stub_op  <= du_sqrtOp;
        stub_val <= du_a ^ du_b;
      end
    end
  end

  assign du_inReady_div    = ready_div;
  assign du_inReady_sqrt   = ready_sqrt;
  assign du_outValid_div   = spur_div  || (stub_cnt == 1 && !stub_op);
  assign du_outValid_sqrt  = spur_sqrt || (stub_cnt == 1 && stub_op);
  assign du_out            = stub_val;
  assign du_exceptionFlags = 5'h01;

  // Reference model: one op in flight, queue of expected responses.
  typedef struct {
    logic [64:0]      out;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t pending;
  logic model_busy = 1'b0;
  logic model_op = 1'b0;
  logic model_killed = 1'b0;

  logic             obs_busy;
  logic             obs_resp_valid;
  logic             obs_req_ready;
  logic             obs_fire;
  logic [TAG_W-1:0] obs_resp_tag;

  int check_count = 0;
  int error_count = 0;

  task automatic checkOutput(input string name, input logic [64:0] actual, input logic [64:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic sqrt, input logic [TAG_W-1:0] tag);
    req_valid = valid;
    req_sqrt  = sqrt;
    req_tag   = tag;
    req_a     = {1'($urandom()), $urandom(), $urandom()};
    req_b     = {1'($urandom()), $urandom(), $urandom()};
    req_rm    = 3'($urandom());
  endtask

  // One clock cycle: compare DUT against the model mid-cycle, then advance the model.
  task automatic step();
    logic exp_space, exp_ready, m_fire, m_done, m_pop;
    @(negedge clock);
    exp_space = !model_busy && (exp_q.size() < FIFO_DEPTH) && !kill;
    exp_ready = exp_space && (req_sqrt ? ready_sqrt : ready_div);
    obs_busy       = busy;
    obs_resp_valid = resp_valid;
    obs_req_ready  = req_ready;
    obs_fire       = req_valid && req_ready;
    obs_resp_tag   = resp_tag;
    checkOutput("req_ready", req_ready, exp_ready);
    checkOutput("du_inValid", du_inValid, req_valid && exp_space);
    checkOutput("du_sqrtOp", du_sqrtOp, req_sqrt);
    checkOutput("du_a", du_a, req_a);
    checkOutput("du_b", du_b, req_b);
    checkOutput("busy", busy, model_busy);
    checkOutput("resp_valid", resp_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      checkOutput("resp_out", resp_out, exp_q[0].out);
      checkOutput("resp_flags", resp_flags, exp_q[0].flags);
      checkOutput("resp_tag", resp_tag, exp_q[0].tag);
    end
    m_fire = req_valid && exp_ready;
    m_done = model_busy && (model_op ? du_outValid_sqrt : du_outValid_div);
    m_pop  = (exp_q.size() != 0) && resp_ready;
    @(posedge clock);
    if (kill) begin
      exp_q.delete();
      if (model_busy) model_killed = 1'b1;
    end else if (m_pop) begin
      exp_q.delete(0);
    end
    if (m_done) begin
      if (!model_killed) exp_q.push_back(pending);
      model_busy = 1'b0;
    end
    if (m_fire) begin
      pending      = '{req_a ^ req_b, 5'h01, req_tag};
      model_busy   = 1'b1;
      model_op     = req_sqrt;
      model_killed = 1'b0;
    end
    #1;
  endtask

  task automatic issue_op(input logic sqrt, input logic [TAG_W-1:0] tag, input int lat);
    logic fired;
    fired = 1'b0;
    stub_lat = lat;
    applyStimulus(1'b1, sqrt, tag);
    for (int i = 0; i < 30 && !fired; i++) begin
      step();
      fired = obs_fire;
    end
    checkOutput("issue_fired", fired, 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input logic drain, input int bound);
    int n;
    n = 0;
    while ((model_busy || (drain && exp_q.size() != 0)) && n < bound) begin
      step();
      n++;
    end
    checkOutput("wait_idle_bound", model_busy || (drain && exp_q.size() != 0), 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values.
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_req_ready", req_ready, 1'b0);
    checkOutput("rst_du_inValid", du_inValid, 1'b0);
    checkOutput("rst_resp_valid", resp_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_resp_out", resp_out, 65'h0);
    checkOutput("rst_resp_tag", resp_tag, 6'h0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;

    // Div with tag 0x05, latency 10, resp_ready held high.
    ready_div = 1'b1;
    ready_sqrt = 1'b1;
    resp_ready = 1'b1;
    stub_lat = 10;
    applyStimulus(1'b1, 1'b0, 6'h05);
    step();
    checkOutput("t1_fire", obs_fire, 1'b1);
    req_valid = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      step();
      checkOutput("t1_busy", obs_busy, i <= 10);
      checkOutput("t1_resp_valid", obs_resp_valid, i == 11);
      if (i == 11) checkOutput("t1_tag", obs_resp_tag, 6'h05);
    end
    wait_idle(1'b1, 10);

    // Two sqrt results fill the FIFO; a third request waits for a pop.
    resp_ready = 1'b0;
    issue_op(1'b1, 6'h01, 3);
    wait_idle(1'b0, 20);
    issue_op(1'b1, 6'h02, 4);
    wait_idle(1'b0, 20);
    applyStimulus(1'b1, 1'b0, 6'h03);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("t2_full_block", obs_req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    step();
    checkOutput("t2_fire_after_pop", obs_fire, 1'b1);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    wait_idle(1'b1, 40);

    // Readiness follows the requested op type.
    ready_div = 1'b0;
    ready_sqrt = 1'b1;
    stub_lat = 4;
    applyStimulus(1'b1, 1'b0, 6'h09);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("t3_div_blocked", obs_fire, 1'b0);
    end
    req_sqrt = 1'b1;
    step();
    checkOutput("t3_sqrt_fire", obs_fire, 1'b1);
    req_valid = 1'b0;
    ready_div = 1'b1;
    wait_idle(1'b1, 20);

    // Stray div out-valid in IDLE and during a sqrt op.
    spur_div = 1'b1;
    step();
    spur_div = 1'b0;
    step();
    checkOutput("t4_idle_spur_rv", obs_resp_valid, 1'b0);
    checkOutput("t4_idle_spur_busy", obs_busy, 1'b0);
    issue_op(1'b1, 6'h07, 6);
    step();
    spur_div = 1'b1;
    step();
    spur_div = 1'b0;
    step();
    checkOutput("t4_busy_spur", obs_busy, 1'b1);
    checkOutput("t4_busy_spur_rv", obs_resp_valid, 1'b0);
    wait_idle(1'b1, 20);

`ifdef DIVSQRT_SEQ_KILL_EN
    // Kill three cycles after fire drops the result.
    stub_lat = 10;
    applyStimulus(1'b1, 1'b0, 6'h0a);
    step();
    checkOutput("t5_fire", obs_fire, 1'b1);
    req_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      kill = (i == 3);
      step();
      checkOutput("t5_busy", obs_busy, i <= 10);
      checkOutput("t5_resp_valid", obs_resp_valid, 1'b0);
    end
    kill = 1'b0;
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      ready_div  = ($urandom_range(0, 3) != 0);
      ready_sqrt = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 2) != 0);
      stub_lat   = $urandom_range(1, 6);
      if (!req_valid || obs_fire)
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TAG_W'($urandom()));
      step();
    end
    req_valid = 1'b0;
    ready_div = 1'b1;
    ready_sqrt = 1'b1;
    resp_ready = 1'b1;
    wait_idle(1'b1, 50);

    // Leave a result in FIFO storage, then reset in cycle 4 of a busy op.
    resp_ready = 1'b0;
    issue_op(1'b0, 6'h15, 2);
    wait_idle(1'b0, 20);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    issue_op(1'b0, 6'h2a, 10);
    for (int i = 0; i < 3; i++) step();
    #2;
    reset = 1'b0;
    ready_div = 1'b0;
    ready_sqrt = 1'b0;
    req_valid = 1'b0;
    #1;
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_resp_valid", resp_valid, 1'b0);
    checkOutput("t6_req_ready", req_ready, 1'b0);
    checkOutput("t6_du_inValid", du_inValid, 1'b0);
    checkOutput("t6_resp_out", resp_out, 65'h0);
    checkOutput("t6_resp_flags", resp_flags, 5'h0);
    checkOutput("t6_resp_tag", resp_tag, 6'h0);
    exp_q.delete();
    model_busy = 1'b0;
    model_killed = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    ready_div = 1'b1;
    ready_sqrt = 1'b1;
    resp_ready = 1'b1;
    issue_op(1'b1, 6'h11, 3);
    wait_idle(1'b1, 20);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/div_sqrt_rec_f64_seq.md
# div_sqrt_rec_f64_seq

Issue/response sequencer wrapped around the BOOM `DivSqrtRecF64` unit: it accepts tagged div/sqrt requests over a valid/ready port, drives the unit's input handshake, tracks the single in-flight operation, and captures the unit's un-backpressurable result into a small response FIFO with a valid/ready output port. It sits directly upstream and downstream of the unit, between the FP issue slot and FP writeback. All control decisions depend only on handshake signals and `req_sqrt`, never on operand or result values, so the sequencer adds no data-dependent timing to the unit under UPEC-DIT analysis.

## Interface
- `TAG_W`, 6, width of the request/response tag
- `FIFO_DEPTH`, 2, response FIFO entries, power of two, ≥2
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `req_valid` in 1 / `req_ready` out 1: request handshake
- `req_sqrt` in 1: 1 = sqrt(b), 0 = a/b
- `req_a`, `req_b` in 65: recoded f64 operands
- `req_rm` in 3: rounding mode
- `req_tag` in TAG_W: opaque tag, returned with the result
- `du_inValid` out 1, `du_sqrtOp` out 1, `du_a` out 65, `du_b` out 65, `du_roundingMode` out 3: unit inputs
- `du_inReady_div`, `du_inReady_sqrt` in 1: unit readiness
- `du_outValid_div`, `du_outValid_sqrt` in 1, `du_out` in 65, `du_exceptionFlags` in 5: unit results
- `resp_valid` out 1 / `resp_ready` in 1: response handshake
- `resp_out` out 65, `resp_flags` out 5, `resp_tag` out TAG_W: head FIFO entry
- `busy` out 1: high while an operation is in flight (BUSY)
- `kill` in 1: flush; present only with `DIVSQRT_SEQ_KILL_EN`

## Operation
- FSM has two states. IDLE: no op in flight. BUSY: one op in flight; `op_sqrt`, `op_tag` and `killed` registered.
- `can_issue` = IDLE && `fifo_count + 0 < FIFO_DEPTH`. A free slot is reserved before issue because the unit cannot be stalled.
- `du_inValid` = `req_valid && can_issue`. `du_*` operands are a combinational pass-through of `req_*`.
- `req_ready` = `can_issue && (req_sqrt ? du_inReady_sqrt : du_inReady_div)`.
- Fire (`req_valid && req_ready`): IDLE→BUSY. Latch `op_sqrt`, `op_tag`, and clear `killed`.
- In BUSY, the completion pulse is `op_sqrt ? du_outValid_sqrt : du_outValid_div`. On completion: BUSY→IDLE, and {`du_out`, `du_exceptionFlags`, `op_tag`} are pushed unless `killed`.
- Out-valid pulses in IDLE, and the non-matching pulse in BUSY, are ignored. With assertions enabled, they flag an error.
- FIFO pop on `resp_valid && resp_ready`. Push and pop in the same cycle keep the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- `resp_*` reflect the head entry. They are stable while `resp_valid && !resp_ready`.

## Timing
- Reset values: state IDLE, FIFO empty, `req_ready` 0 (can_issue is true, but it follows the du readiness inputs combinationally), `du_inValid` 0, `resp_valid` 0, `busy` 0, `resp_out`/`resp_flags`/`resp_tag` 0.
- Issue costs zero added cycles: a request fires in the same cycle the unit accepts it.
- Result latency: completion in cycle N → `resp_valid` = 1 in cycle N+1.
- A new request may fire in cycle N+1 after completion in cycle N. Back-to-back issue is not possible in the completion cycle itself.
- Reset asserted mid-operation clears the state and the FIFO immediately. The unit is reset by the same signal, so no stale completion is expected.

## Configuration
- Macro `DIVSQRT_SEQ_KILL_EN`.
- Defined: `kill` port exists, with this behaviour:
  - `kill` in IDLE empties the FIFO that cycle.
  - `kill` in BUSY sets `killed` and empties the FIFO. The state stays BUSY until the completion pulse, which is then dropped.
  - `req_ready` is forced 0 in any cycle with `kill`=1.
- Not defined: no port, no `killed` flag. Every completion is pushed.

## Structure
- Package `div_sqrt_seq_pkg`: state enum (`DSQ_IDLE`, `DSQ_BUSY`), `resp_entry_t` struct {out[64:0], flags[4:0], tag}, recoded-f64 width constant 65.
- Sub-module `div_sqrt_resp_fifo`: parameterised synchronous FIFO of `resp_entry_t` with count output. FSM and handshake logic stay in the top.

## Test plan
Bench uses a stub unit that drives `du_out = a ^ b` and flags `5'h01` a configurable L cycles after accept.
- Div request, tag 0x05, L=10, `resp_ready`=1 → fire in cycle 0, `busy` cycles 1–10, `resp_valid` in cycle 11 with tag 0x05 and `resp_out = a^b`.
- Two sqrt ops with `resp_ready`=0 → both results queued and FIFO full. A third request sees `req_ready`=0 until one pop.
- `du_inReady_div`=0, `du_inReady_sqrt`=1, div request held → no fire. Switching to sqrt fires in the same cycle.
- Spurious `du_outValid_div` in IDLE and while BUSY on sqrt → no push, state unchanged.
- (KILL_EN) `kill` 3 cycles after fire, L=10 → completion dropped, `resp_valid` stays 0, `busy` falls in cycle 11.
- Reset pulse at cycle 4 of a BUSY op → all outputs return to reset values asynchronously, and the next request fires normally.
